// File: rtl/mbscore_mem_arbiter_pkg.sv
// rtl/mbscore_mem_arbiter_pkg.sv - shared constants for the MBScore memory arbiter
package mbscore_mem_arbiter_pkg;

  localparam int MBS_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

endpackage

// File: rtl/mbscore_arb_pick.sv
// rtl/mbscore_arb_pick.sv - 2-way fetch/data picker; MBSCORE_MEM_ARB_RR_EN selects round-robin ties
module mbscore_arb_pick
  import mbscore_mem_arbiter_pkg::*;
(
  input  logic if_req_i,
  input  logic dm_req_i,
  input  logic last_own_i,
  output logic any_o,
  output logic win_o
);

  assign any_o = if_req_i | dm_req_i;

`ifdef MBSCORE_MEM_ARB_RR_EN
  // On a tie the port that did not own the previous transaction wins
  always_comb begin
    win_o = dm_req_i ? OWN_DM : OWN_IF;
    if (if_req_i && dm_req_i) begin
      win_o = ~last_own_i;
    end
  end
`else
  logic unused_last_own;
  assign unused_last_own = last_own_i;
  assign win_o = dm_req_i ? OWN_DM : OWN_IF;
`endif

endmodule

// File: rtl/mbscore_mem_arbiter.sv
// rtl/mbscore_mem_arbiter.sv - IF/MEM arbiter for a single-ported variable-latency memory
// Optional round-robin tie-break: define MBSCORE_MEM_ARB_RR_EN.
module mbscore_mem_arbiter
  import mbscore_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = MBS_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  output logic                    if_gnt_o,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,
  output logic                    if_done_o,
  input  logic                    dm_req_i,
  input  logic                    dm_we_i,
  input  logic [DATA_WIDTH/8-1:0] dm_be_i,
  input  logic [ADDR_WIDTH-1:0]   dm_addr_i,
  input  logic [DATA_WIDTH-1:0]   dm_wdata_i,
  output logic                    dm_gnt_o,
  output logic [DATA_WIDTH-1:0]   dm_rdata_o,
  output logic                    dm_done_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic                    mem_ready_i,
  output logic                    busy_o
);

  localparam int BE_W = DATA_WIDTH / 8;

  arb_state_e            state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [BE_W-1:0]       mem_be_q, mem_be_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  if_gnt_q, if_gnt_d;
  logic                  dm_gnt_q, dm_gnt_d;
  logic                  if_done_q, if_done_d;
  logic                  dm_done_q, dm_done_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
  logic                  busy_q, busy_d;

  logic any_req;
  logic win;
  logic last_own;

  mbscore_arb_pick u_pick (
    .if_req_i   (if_req_i),
    .dm_req_i   (dm_req_i),
    .last_own_i (last_own),
    .any_o      (any_req),
    .win_o      (win)
  );

`ifdef MBSCORE_MEM_ARB_RR_EN
  logic last_own_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_own_q <= OWN_IF;
    end else if (state_q == ARB_IDLE && any_req) begin
      last_own_q <= win;
    end
  end
  assign last_own = last_own_q;
`else
  assign last_own = OWN_IF;
`endif

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_gnt_d    = if_gnt_q;
    dm_gnt_d    = dm_gnt_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          state_d   = ARB_BUSY;
          mem_req_d = 1'b1;
          if (win == OWN_DM) begin
            dm_gnt_d    = 1'b1;
            mem_we_d    = dm_we_i;
            mem_be_d    = dm_be_i;
            mem_addr_d  = dm_addr_i;
            mem_wdata_d = dm_wdata_i;
          end else begin
            if_gnt_d    = 1'b1;
            mem_we_d    = 1'b0;
            mem_be_d    = '1;
            mem_addr_d  = if_addr_i;
            mem_wdata_d = '0;
          end
        end
      end
      ARB_BUSY: begin
        // Memory fields stay frozen until the access completes
        if (mem_ready_i) begin
          state_d   = ARB_DONE;
          mem_req_d = 1'b0;
          if (dm_gnt_q) begin
            dm_done_d = 1'b1;
            if (!mem_we_q) begin
              dm_rdata_d = mem_rdata_i;
            end
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_rdata_i;
          end
        end
      end
      ARB_DONE: begin
        state_d  = ARB_IDLE;
        if_gnt_d = 1'b0;
        dm_gnt_d = 1'b0;
      end
      default: begin
        state_d   = ARB_IDLE;
        mem_req_d = 1'b0;
        if_gnt_d  = 1'b0;
        dm_gnt_d  = 1'b0;
      end
    endcase
    busy_d = (state_d != ARB_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_gnt_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_gnt_q    <= if_gnt_d;
      dm_gnt_q    <= dm_gnt_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign if_gnt_o    = if_gnt_q;
  assign if_rdata_o  = if_rdata_q;
  assign if_done_o   = if_done_q;
  assign dm_gnt_o    = dm_gnt_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign dm_done_o   = dm_done_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_mbscore_mem_arbiter.sv
// tb/tb_mbscore_mem_arbiter.sv - directed self-checking bench for mbscore_mem_arbiter
module tb_mbscore_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_done;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_done;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_ready, busy;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int dm_done_cnt = 0;
  int excl_err = 0;

  always #5 clk = ~clk;

  mbscore_mem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_gnt_o    (if_gnt),
    .if_rdata_o  (if_rdata),
    .if_done_o   (if_done),
    .dm_req_i    (dm_req),
    .dm_we_i     (dm_we),
    .dm_be_i     (dm_be),
    .dm_addr_i   (dm_addr),
    .dm_wdata_i  (dm_wdata),
    .dm_gnt_o    (dm_gnt),
    .dm_rdata_o  (dm_rdata),
    .dm_done_o   (dm_done),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_be_o    (mem_be),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .mem_ready_i (mem_ready),
    .busy_o      (busy)
  );

  always @(negedge clk) begin
    if (dm_done === 1'b1) dm_done_cnt <= dm_done_cnt + 1;
    if (!rst && ((if_gnt && dm_gnt) || (mem_req && !(if_gnt ^ dm_gnt))))
      excl_err <= excl_err + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Returns at the negedge where a done pulse is visible; owner 1 = data port
  task automatic await_done(input string tag, output logic owner);
    int n;
    owner = 1'b0;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (if_done === 1'b1 || dm_done === 1'b1) break;
    end
    check({tag, "_timeout"}, 32'(n >= 40), 32'd0);
    owner = dm_done;
  endtask

  function automatic logic tie_winner(input logic last);
`ifdef MBSCORE_MEM_ARB_RR_EN
    return ~last;
`else
    return last | 1'b1;
`endif
  endfunction

  logic        own, last_model, exp_own, stable;
  logic [31:0] exp_if_rdata, exp_dm_rdata;
  int          snap;

  initial begin
    rst = 1'b1;
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_be = 0;
    dm_addr = 0; dm_wdata = 0; mem_rdata = 0; mem_ready = 0;
    repeat (2) @(negedge clk);
    check("rst_mem_req", {31'd0, mem_req}, 0);
    check("rst_gnt", {30'd0, if_gnt, dm_gnt}, 0);
    check("rst_done", {30'd0, if_done, dm_done}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_rdata", if_rdata | dm_rdata, 0);
    check("rst_mem_fields", mem_addr | mem_wdata | {27'd0, mem_we, mem_be}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Fetch only, ready on the 2nd BUSY cycle
    if_req = 1; if_addr = 32'h0000_0040; mem_rdata = 32'h2008_0005;
    @(negedge clk);
    check("f_busy1_req", {31'd0, mem_req}, 1);
    check("f_gnt", {30'd0, if_gnt, dm_gnt}, 32'b10);
    check("f_addr", mem_addr, 32'h40);
    check("f_we_be", {27'd0, mem_we, mem_be}, 32'h0F);
    check("f_wdata", mem_wdata, 0);
    check("f_busy", {31'd0, busy}, 1);
    @(negedge clk);
    check("f_busy2_req", {31'd0, mem_req}, 1);
    check("f_busy2_done", {31'd0, if_done}, 0);
    mem_ready = 1;
    @(negedge clk);
    check("f_done", {30'd0, if_done, dm_done}, 32'b10);
    check("f_rdata", if_rdata, 32'h2008_0005);
    check("f_done_req", {31'd0, mem_req}, 0);
    check("f_done_gnt", {30'd0, if_gnt, dm_gnt}, 32'b10);
    if_req = 0; mem_ready = 0;
    @(negedge clk);
    check("f_idle", {28'd0, if_done, if_gnt, dm_gnt, busy}, 0);
    last_model = 1'b0;
    exp_if_rdata = 32'h2008_0005;

    // Store with ready tied high; garbage on mem_rdata must not be captured
    dm_req = 1; dm_we = 1; dm_be = 4'b0011; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
    mem_ready = 1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    check("s_we_be", {27'd0, mem_we, mem_be}, 32'h13);
    check("s_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("s_addr", mem_addr, 32'h100);
    check("s_gnt", {29'd0, mem_req, if_gnt, dm_gnt}, 32'b101);
    @(negedge clk);
    check("s_done", {30'd0, if_done, dm_done}, 32'b01);
    check("s_rdata_kept", dm_rdata, 0);
    check("s_done_req", {31'd0, mem_req}, 0);
    dm_req = 0; dm_we = 0; mem_ready = 0;
    @(negedge clk);
    check("s_idle", {30'd0, dm_done, busy}, 0);
    last_model = 1'b1;
    exp_dm_rdata = 32'd0;

    // Simultaneous requests: winner drops, loser follows
    if_req = 1; if_addr = 32'h44; dm_req = 1; dm_addr = 32'h200; dm_be = 4'hF;
    mem_ready = 1; mem_rdata = 32'hA000_0000;
    exp_own = tie_winner(last_model);
    await_done("tie1", own);
    check("tie1_owner", {31'd0, own}, {31'd0, exp_own});
    if (exp_own) begin exp_dm_rdata = mem_rdata; dm_req = 0; end
    else begin exp_if_rdata = mem_rdata; if_req = 0; end
    last_model = exp_own;
    mem_rdata = 32'hA000_0001;
    await_done("tie1b", own);
    check("tie1b_owner", {31'd0, own}, {31'd0, ~exp_own});
    if (own) exp_dm_rdata = mem_rdata; else exp_if_rdata = mem_rdata;
    check("tie1b_if_rdata", if_rdata, exp_if_rdata);
    check("tie1b_dm_rdata", dm_rdata, exp_dm_rdata);
    last_model = ~exp_own;

    // Both held for four transactions
    if_req = 1; dm_req = 1;
    for (int k = 0; k < 4; k++) begin
      mem_rdata = 32'hB000_0000 + 32'(k);
      exp_own = tie_winner(last_model);
      await_done($sformatf("hold%0d", k), own);
      check($sformatf("hold%0d_owner", k), {31'd0, own}, {31'd0, exp_own});
      if (exp_own) exp_dm_rdata = mem_rdata; else exp_if_rdata = mem_rdata;
      last_model = exp_own;
    end
    check("hold_if_rdata", if_rdata, exp_if_rdata);
    check("hold_dm_rdata", dm_rdata, exp_dm_rdata);
    if_req = 0; dm_req = 0; mem_ready = 0;
    @(negedge clk);

    // Long latency load; requester drops req and changes addr mid-transaction
    dm_req = 1; dm_we = 0; dm_addr = 32'h300; mem_rdata = 32'hCCCC_0003;
    snap = dm_done_cnt;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      stable &= (mem_req === 1'b1) && (mem_addr === 32'h300) && (busy === 1'b1)
                && (dm_gnt === 1'b1) && (dm_done === 1'b0);
      if (i == 0) begin dm_addr = 32'h999; dm_req = 0; end
    end
    check("lat_stable", {31'd0, stable}, 1);
    mem_ready = 1;
    await_done("lat", own);
    check("lat_owner", {31'd0, own}, 1);
    check("lat_rdata", dm_rdata, 32'hCCCC_0003);
    last_model = 1'b1;
    // Ready stays high in IDLE with nothing requested
    mem_rdata = 32'hDDDD_0004;
    repeat (3) @(negedge clk);
    check("lat_one_done", 32'(dm_done_cnt - snap), 1);
    check("idle_ready_state", {29'd0, busy, mem_req, if_done | dm_done}, 0);
    check("idle_ready_dm_rdata", dm_rdata, 32'hCCCC_0003);
    check("idle_ready_if_rdata", if_rdata, exp_if_rdata);

    // Reset on the 3rd BUSY cycle, then re-grant of the held request
    mem_ready = 0; dm_req = 1; dm_addr = 32'h400;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rstb_mem_req", {31'd0, mem_req}, 0);
    check("rstb_gnt", {30'd0, if_gnt, dm_gnt}, 0);
    check("rstb_busy", {31'd0, busy}, 0);
    check("rstb_rdata", if_rdata | dm_rdata, 0);
    @(negedge clk);
    rst = 1'b0; mem_ready = 1; mem_rdata = 32'hEEEE_0005;
    await_done("regrant", own);
    check("regrant_owner", {31'd0, own}, 1);
    check("regrant_addr", mem_addr, 32'h400);
    check("regrant_rdata", dm_rdata, 32'hEEEE_0005);
    dm_req = 0; mem_ready = 0;
    repeat (2) @(negedge clk);

    check("gnt_exclusive", 32'(excl_err), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
